burst_gate: RTL

- Generates the `burst_active` window consumed by the chroma loop filter.
- Qualifies incoming composite sync and measures sync-tip width, rejecting glitches, equalizing pulses and broad (vertical) pulses.
- Opens a fixed-length gate at a fixed delay after each valid horizontal sync, so the loop filter only integrates over the colour burst.
- Sits between the sync separator and the loop filter, in the same clock domain as both.

---
 rtl/burst_gate_pkg.sv | 18 +
 rtl/burst_gate_if.sv | 24 ++
 rtl/burst_gate.sv | 113 +++++++++++
 3 files changed

// File: rtl/burst_gate_pkg.sv
// Shared state encoding and default timing for the burst gate, the sync separator and the bench.
package burst_gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        DELAY = 2'd2,
        BURST = 2'd3
    } bg_state_t;

    localparam int BG_CNT_W       = 12;
    localparam int BG_SYNC_MIN    = 40;
    localparam int BG_SYNC_MAX    = 80;
    localparam int BG_BURST_DELAY = 20;
    localparam int BG_BURST_LEN   = 64;
    localparam int BG_HOLDOFF     = 400;

endpackage

// File: rtl/burst_gate_if.sv
// Sync-in / gate-out bundle between the sync separator (master) and the burst gate (slave).
interface burst_gate_if;
    logic enable;
    logic sync_n;
    logic burst_active;
    logic line_strobe;
    logic broad_pulse;

    modport master (
        output enable,
        output sync_n,
        input  burst_active,
        input  line_strobe,
        input  broad_pulse
    );

    modport slave (
        input  enable,
        input  sync_n,
        output burst_active,
        output line_strobe,
        output broad_pulse
    );
endinterface

// File: rtl/burst_gate.sv
// Qualifies composite h-sync by tip width and line holdoff, then opens the colour-burst
// window a fixed delay after each accepted sync.
module burst_gate
    import burst_gate_pkg::*;
#(
    parameter int CNT_W       = BG_CNT_W,
    parameter int SYNC_MIN    = BG_SYNC_MIN,
    parameter int SYNC_MAX    = BG_SYNC_MAX,
    parameter int BURST_DELAY = BG_BURST_DELAY,
    parameter int BURST_LEN   = BG_BURST_LEN,
    parameter int HOLDOFF     = BG_HOLDOFF
) (
    input  logic         clk,
    input  logic         rst,
    burst_gate_if.slave  bus
);

    localparam logic [CNT_W-1:0] SMIN   = CNT_W'(SYNC_MIN);
    localparam logic [CNT_W-1:0] SMAX   = CNT_W'(SYNC_MAX);
    localparam logic [CNT_W-1:0] HO     = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(BURST_DELAY - 1);
    localparam logic [CNT_W-1:0] LEN_LD = CNT_W'(BURST_LEN - 1);

    generate
        if (SYNC_MAX >= (1 << CNT_W) - 1) begin : g_bad_sync_max
            $error("burst_gate: SYNC_MAX must be below the width counter saturation value");
        end
        if (HOLDOFF >= (1 << CNT_W)) begin : g_bad_holdoff
            $error("burst_gate: HOLDOFF does not fit in CNT_W bits");
        end
        if (BURST_DELAY < 1 || BURST_DELAY > (1 << CNT_W)) begin : g_bad_delay
            $error("burst_gate: BURST_DELAY out of range");
        end
        if (BURST_LEN < 1 || BURST_LEN > 127) begin : g_bad_len
            $error("burst_gate: BURST_LEN must be 1..127");
        end
    endgenerate

    bg_state_t        state, state_nxt;
    logic             sync_d;
    logic             fall, rise, rise_eval;
    logic [CNT_W-1:0] width, holdoff, gate_cnt;
    logic             too_long, too_short, holdoff_ok, gate_done, accept;
    logic             strobe_nxt, broad_nxt, burst_nxt;

    assign fall       = sync_d & ~bus.sync_n;
    assign rise       = ~sync_d & bus.sync_n;
    assign too_long   = width > SMAX;
    assign too_short  = width < SMIN;
    assign holdoff_ok = holdoff >= HO;
    assign gate_done  = (gate_cnt == '0);
    assign rise_eval  = bus.enable & (state == SYNC) & rise;
    assign accept     = rise_eval & ~too_long & ~too_short & holdoff_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = SYNC;
            SYNC:  if (rise) state_nxt = accept ? DELAY : IDLE;
            // A new sync tip inside the window truncates the burst and is measured afresh.
            DELAY: if (fall) state_nxt = SYNC;
                   else if (gate_done) state_nxt = BURST;
            BURST: if (fall) state_nxt = SYNC;
                   else if (gate_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!bus.enable) state_nxt = IDLE;
    end

    always_comb begin
        strobe_nxt = accept;
        broad_nxt  = rise_eval & too_long;
        burst_nxt  = (state_nxt == BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_d           <= 1'b1;
            width            <= '0;
            holdoff          <= HO;
            gate_cnt         <= '0;
            bus.burst_active <= 1'b0;
            bus.line_strobe  <= 1'b0;
            bus.broad_pulse  <= 1'b0;
        end else begin
            sync_d           <= bus.sync_n;
            bus.burst_active <= burst_nxt;
            bus.line_strobe  <= strobe_nxt;
            bus.broad_pulse  <= broad_nxt;

            if (accept)          holdoff <= '0;
            else if (!holdoff_ok) holdoff <= holdoff + 1'b1;

            // The fall cycle itself counts as the first low clock.
            if (fall)                               width <= CNT_W'(1);
            else if (state == SYNC && width != '1)  width <= width + 1'b1;

            // One counter serves both the delay and the burst length.
            if (accept)
                gate_cnt <= DLY_LD;
            else if (state == DELAY && gate_done)
                gate_cnt <= LEN_LD;
            else if ((state == DELAY || state == BURST) && !gate_done)
                gate_cnt <= gate_cnt - 1'b1;
        end
    end

endmodule
